hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Hazard controller for a five-stage (F/D/E/M/W) in-order pipeline.
//   * Operand forwarding select for the ALU in E (M result beats W result).
//   * Load-use / RAW stall detection for the instruction in D.
//   * Branch/jump flush of D and E when a redirect resolves in E.
//   * Data-memory wait handling: a small FSM (RUN / MEMWAIT / ERR) freezes
//     the pipeline while the data memory is not ready and latches a sticky
//     error if the wait exceeds TIMEOUT cycles.
//   * Free-running 32-bit count of cycles in which fetch was stalled.
//
// Build option:
//   HAZARD_FORWARD_EN  defined   -> forwarding enabled; only load-use stalls.
//                      undefined -> forwarding selects tied to 00; any RAW
//                                   dependency on E or M stalls D instead.
//
// Parameters:
//   TIMEOUT  maximum memory-wait cycles before ERR (0 = never time out)
//   WIDTH    register-index width
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   Rs1D, Rs2D                   source indices of the instruction in D
//   Rs1E, Rs2E, RdE              source/dest indices of the instruction in E
//   RdM, RdW                     dest indices in M and W
//   RegWriteE/M/W                write enables of E/M/W
//   ResultSrcE                   result source in E (2'b01 = load)
//   PCSrcE                       branch/jump taken in E
//   MemReqM, MemReadyM           data-memory request / ready in M
//   StallF/D/E/M                 hold PC and D/E/M pipeline registers
//   FlushD/E/W                   clear D/E/W pipeline registers
//   ForwardAE, ForwardBE         ALU operand select (00 RF, 01 W, 10 M)
//   MemErr                       sticky memory-timeout error
//   StallCount                   number of cycles with StallF=1 (wrapping)
// ============================================================================
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned WIDTH   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Rs1D,
    input  logic [WIDTH-1:0] Rs2D,
    input  logic [WIDTH-1:0] Rs1E,
    input  logic [WIDTH-1:0] Rs2E,
    input  logic [WIDTH-1:0] RdE,
    input  logic [WIDTH-1:0] RdM,
    input  logic [WIDTH-1:0] RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [31:0]      StallCount
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] wait_cnt_reg;
    logic        mem_err_reg;
    logic [31:0] stall_count_reg;

    // ------------------------------------------------------------------
    // Memory stall and global hold
    // ------------------------------------------------------------------
    logic mem_stall;
    logic in_err;
    logic hold;

    // In ERR the memory handshake is ignored; the pipeline is frozen anyway.
    assign in_err    = (state_reg == ERR);
    assign mem_stall = !in_err && MemReqM && !MemReadyM;
    assign hold      = mem_stall || in_err;

    // Saturating increment of the wait counter.
    logic [15:0] wait_cnt_next;
    assign wait_cnt_next = (wait_cnt_reg == 16'hFFFF) ? wait_cnt_reg
                                                      : wait_cnt_reg + 16'd1;

    // TIMEOUT=0 disables the timeout. A TIMEOUT above the counter range is
    // never reached because the counter saturates.
    function automatic logic timeout_hit(input logic [15:0] cnt);
        return (TIMEOUT != 0) && (32'(cnt) >= TIMEOUT);
    endfunction

    // ------------------------------------------------------------------
    // Memory-wait FSM (MemErr is registered alongside the state)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_stall) begin
                        // First stalled edge counts as wait cycle 1.
                        wait_cnt_reg <= 16'd1;
                        if (timeout_hit(16'd1)) begin
                            state_reg   <= ERR;
                            mem_err_reg <= 1'b1;
                        end else begin
                            state_reg <= MEMWAIT;
                        end
                    end
                end
                MEMWAIT: begin
                    // Ready or a withdrawn request ends the wait; the stalls
                    // are already low this cycle because mem_stall is low.
                    if (!MemReqM || MemReadyM) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (timeout_hit(wait_cnt_next)) begin
                            state_reg   <= ERR;
                            mem_err_reg <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    // Terminal until reset.
                    mem_err_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= RUN;
                    wait_cnt_reg <= '0;
                    mem_err_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign MemErr = mem_err_reg;

    // ------------------------------------------------------------------
    // Stall-cycle counter (wraps naturally at 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (StallF) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign StallCount = stall_count_reg;

    // ------------------------------------------------------------------
    // Per-operand dependency checks. Index 0 = rs1, index 1 = rs2.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rs_d [2];
    logic [WIDTH-1:0] rs_e [2];
    logic [1:0]       fwd_sel [2];
    logic [1:0]       load_use_hit;
    logic [1:0]       raw_hit;

    assign rs_d[0] = Rs1D;
    assign rs_d[1] = Rs2D;
    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    logic load_in_e;
    assign load_in_e = (ResultSrcE == 2'b01);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            // Load in E whose destination is read in D: the value is not
            // available until after M, so D must wait one cycle.
            assign load_use_hit[gi] = load_in_e && (RdE != '0) &&
                                      (RdE == rs_d[gi]);

`ifdef HAZARD_FORWARD_EN
            // With forwarding only the load-use case needs a stall.
            assign raw_hit[gi] = load_use_hit[gi];

            // Youngest producer wins: M beats W. Register 0 is never
            // forwarded since it is hard-wired to zero.
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (RegWriteM && (RdM != '0) && (RdM == rs_e[gi])) begin
                    fwd_sel[gi] = 2'b10;
                end else if (RegWriteW && (RdW != '0) && (RdW == rs_e[gi])) begin
                    fwd_sel[gi] = 2'b01;
                end
            end
`else
            // Without forwarding, any pending write in E or M to a register
            // read in D must drain before D may proceed. W is not checked:
            // the register file is assumed to write-before-read.
            assign raw_hit[gi] = load_use_hit[gi] ||
                                 ((rs_d[gi] != '0) &&
                                  ((RegWriteE && (RdE == rs_d[gi])) ||
                                   (RegWriteM && (RdM == rs_d[gi]))));

            assign fwd_sel[gi] = 2'b00;
`endif
        end
    endgenerate

    assign ForwardAE = fwd_sel[0];
    assign ForwardBE = fwd_sel[1];

    // Inputs only consumed in one build flavour are folded here so that the
    // other flavour carries no dangling signals.
`ifdef HAZARD_FORWARD_EN
    logic unused_inputs;
    assign unused_inputs = ^{1'b0, RegWriteE};
`else
    logic unused_inputs;
    assign unused_inputs = ^{1'b0, rs_e[0], rs_e[1], RdW, RegWriteW};
`endif

    logic data_hazard;
    assign data_hazard = |raw_hit;

    // ------------------------------------------------------------------
    // Stall / flush priority: memory hold > branch flush > data stall
    // ------------------------------------------------------------------
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (hold) begin
            // Freeze everything up to M and drop the instruction leaving M
            // so W does not retire it twice.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            // Wrong-path instructions in D and E are squashed; this also
            // cancels any load-use stall since D is being discarded.
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (data_hazard) begin
            // Hold F and D, inject a bubble into E.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

endmodule
